// File: rtl/mm_step_scheduler.sv
// Step scheduler for one fiber-positioner channel: shares a single microsecond
// throttle between the theta and phi step generators, one throttle period per
// step, interleaving the two motors round-robin until both counts are spent.
module mm_step_scheduler #(
    parameter int unsigned REG_W = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock_16mhz,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_theta_steps,
    input  logic [CNT_W-1:0] cmd_phi_steps,
    input  logic [REG_W-1:0] cmd_step_len,
    input  logic             abort,
    output logic             thr_start,
    output logic [REG_W-1:0] thr_step_len,
    input  logic             thr_done,
    output logic             theta_step,
    output logic             phi_step,
    output logic             busy,
    output logic [CNT_W-1:0] theta_left,
    output logic [CNT_W-1:0] phi_left,
    output logic             move_done,
    output logic             aborted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_START  = 3'd2,
        S_ARM    = 3'd3,
        S_WAIT   = 3'd4,
        S_STEP   = 3'd5,
        S_FINISH = 3'd6
    } state_t;

    // Motor identifiers used by the round-robin pointer and the selection.
    localparam logic MOTOR_THETA = 1'b0;
    localparam logic MOTOR_PHI   = 1'b1;

    state_t             state_q,      state_d;
    logic [CNT_W-1:0]   theta_q,      theta_d;
    logic [CNT_W-1:0]   phi_q,        phi_d;
    logic [REG_W-1:0]   len_q,        len_d;
    logic               ptr_q,        ptr_d;
    logic               sel_q,        sel_d;
    logic               aborted_q,    aborted_d;
    logic               thr_start_q,  thr_start_d;
    logic               theta_step_q, theta_step_d;
    logic               phi_step_q,   phi_step_d;
    logic               move_done_q,  move_done_d;
    logic               cmd_ready_q,  cmd_ready_d;
    logic               busy_q,       busy_d;

    // Next-state and next-output computation; abort overrides the normal flow.
    always_comb begin
        state_d      = state_q;
        theta_d      = theta_q;
        phi_d        = phi_q;
        len_d        = len_q;
        ptr_d        = ptr_q;
        sel_d        = sel_q;
        aborted_d    = aborted_q;
        theta_step_d = 1'b0;
        phi_step_d   = 1'b0;
        move_done_d  = 1'b0;
        thr_start_d  = 1'b0;
        cmd_ready_d  = 1'b0;
        busy_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    theta_d   = cmd_theta_steps;
                    phi_d     = cmd_phi_steps;
                    len_d     = cmd_step_len;
                    aborted_d = 1'b0;
                    ptr_d     = MOTOR_THETA;
                    state_d   = S_SELECT;
                end
            end
            S_SELECT: begin
                if ((theta_q == '0) && (phi_q == '0)) begin
                    state_d = S_FINISH;
                end else begin
                    // Prefer the pointer motor; fall back to the other one.
                    if (ptr_q == MOTOR_THETA) begin
                        sel_d = (theta_q != '0) ? MOTOR_THETA : MOTOR_PHI;
                    end else begin
                        sel_d = (phi_q != '0) ? MOTOR_PHI : MOTOR_THETA;
                    end
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_ARM;
            end
            S_ARM: begin
                // thr_done is still the stale value from before the load here.
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (thr_done) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (sel_q == MOTOR_THETA) begin
                    theta_step_d = 1'b1;
                    if (theta_q != '0) begin
                        theta_d = theta_q - CNT_W'(1);
                    end
                end else begin
                    phi_step_d = 1'b1;
                    if (phi_q != '0) begin
                        phi_d = phi_q - CNT_W'(1);
                    end
                end
                ptr_d   = ~sel_q;
                state_d = S_SELECT;
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        move_done_d = (state_d == S_FINISH);

        // Abort kills the move from any active state, including FINISH.
        if (abort && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            theta_d      = '0;
            phi_d        = '0;
            theta_step_d = 1'b0;
            phi_step_d   = 1'b0;
            aborted_d    = 1'b1;
            move_done_d  = 1'b1;
        end

        thr_start_d = (state_d == S_START);
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock_16mhz or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            theta_q      <= '0;
            phi_q        <= '0;
            len_q        <= '0;
            ptr_q        <= MOTOR_THETA;
            sel_q        <= MOTOR_THETA;
            aborted_q    <= 1'b0;
            thr_start_q  <= 1'b0;
            theta_step_q <= 1'b0;
            phi_step_q   <= 1'b0;
            move_done_q  <= 1'b0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            theta_q      <= theta_d;
            phi_q        <= phi_d;
            len_q        <= len_d;
            ptr_q        <= ptr_d;
            sel_q        <= sel_d;
            aborted_q    <= aborted_d;
            thr_start_q  <= thr_start_d;
            theta_step_q <= theta_step_d;
            phi_step_q   <= phi_step_d;
            move_done_q  <= move_done_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign thr_start    = thr_start_q;
    assign thr_step_len = len_q;
    assign theta_step   = theta_step_q;
    assign phi_step     = phi_step_q;
    assign busy         = busy_q;
    assign theta_left   = theta_q;
    assign phi_left     = phi_q;
    assign move_done    = move_done_q;
    assign aborted      = aborted_q;

endmodule

// File: tb/tb_mm_step_scheduler.sv
// Directed bench for mm_step_scheduler with a 1 us (16-clock) throttle model.
`timescale 1ns/1ps
module tb_mm_step_scheduler;

    localparam int unsigned REG_W = 16;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_theta_steps = '0;
    logic [CNT_W-1:0] cmd_phi_steps = '0;
    logic [REG_W-1:0] cmd_step_len = '0;
    logic             abort = 1'b0;
    logic             thr_start;
    logic [REG_W-1:0] thr_step_len;
    logic             thr_done;
    logic             theta_step;
    logic             phi_step;
    logic             busy;
    logic [CNT_W-1:0] theta_left;
    logic [CNT_W-1:0] phi_left;
    logic             move_done;
    logic             aborted;

    mm_step_scheduler #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clock_16mhz    (clk),
        .reset          (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_theta_steps(cmd_theta_steps),
        .cmd_phi_steps  (cmd_phi_steps),
        .cmd_step_len   (cmd_step_len),
        .abort          (abort),
        .thr_start      (thr_start),
        .thr_step_len   (thr_step_len),
        .thr_done       (thr_done),
        .theta_step     (theta_step),
        .phi_step       (phi_step),
        .busy           (busy),
        .theta_left     (theta_left),
        .phi_left       (phi_left),
        .move_done      (move_done),
        .aborted        (aborted)
    );

    always #31.25 clk = ~clk;

    // Throttle model: loads on thr_start, counts down once per 16-clock microsecond.
    logic [3:0]       pre;
    logic [REG_W-1:0] tcnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre  <= '0;
            tcnt <= '0;
        end else begin
            pre <= pre + 4'd1;
            if (thr_start)                      tcnt <= thr_step_len;
            else if (pre == 4'd15 && tcnt != 0) tcnt <= tcnt - REG_W'(1);
        end
    end
    assign thr_done = (tcnt == '0);

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int order[$];
    int times[$];
    int thr_n, done_n, done_cyc, len_bad, busy_bad, acc_cyc;
    int exp_len;
    logic prev_done = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (prev_done && busy) busy_bad++;
        prev_done = move_done;
        if (theta_step) begin order.push_back(0); times.push_back(cyc); end
        if (phi_step)   begin order.push_back(1); times.push_back(cyc); end
        if (thr_start) thr_n++;
        if (busy && (32'(thr_step_len) != exp_len)) len_bad++;
        if (move_done) begin done_n++; done_cyc = cyc; end
    endtask

    task automatic clear_log();
        order.delete();
        times.delete();
        thr_n = 0; done_n = 0; done_cyc = 0; len_bad = 0; busy_bad = 0;
    endtask

    task automatic send_cmd(input int t, input int p, input int l);
        cmd_theta_steps = CNT_W'(t);
        cmd_phi_steps   = CNT_W'(p);
        cmd_step_len    = REG_W'(l);
        exp_len         = l;
        cmd_valid       = 1'b1;
        acc_cyc         = cyc;
        tick();
        cmd_valid       = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (done_n == 0 && n < limit) begin tick(); n++; end
        check_eq(tag, 32'(done_n != 0), 1);
    endtask

    initial begin
        int gap;
        int n;
        exp_len = 0;
        clear_log();

        // Reset values
        tick(); tick();
        check_eq("rst_ready",  32'(cmd_ready), 1);
        check_eq("rst_busy",   32'(busy), 0);
        check_eq("rst_theta",  32'(theta_left), 0);
        check_eq("rst_phi",    32'(phi_left), 0);
        check_eq("rst_len",    32'(thr_step_len), 0);
        check_eq("rst_flags",  32'({thr_start, theta_step, phi_step, move_done, aborted}), 0);
        rst = 1'b0;
        tick(); tick();

        // 3 theta + 2 phi, 5 us steps
        clear_log();
        send_cmd(3, 2, 5);
        check_eq("t1_busy", 32'(busy), 1);
        wait_done("t1_timeout", 2000);
        check_eq("t1_npulse", 32'(order.size()), 5);
        for (int i = 0; i < order.size(); i++)
            check_eq("t1_order", 32'(order[i]), 32'(i % 2));
        for (int i = 1; i < times.size(); i++) begin
            gap = times[i] - times[i-1];
            check_eq("t1_gap", 32'(gap >= 4*16+4 && gap <= 6*16+4), 1);
        end
        check_eq("t1_thr_n", 32'(thr_n), 5);
        check_eq("t1_aborted", 32'(aborted), 0);
        check_eq("t1_left", 32'({theta_left, phi_left}), 0);
        tick(); tick();
        check_eq("t1_done_n", 32'(done_n), 1);

        // phi only, 2 us steps
        clear_log();
        send_cmd(0, 4, 2);
        wait_done("t2_timeout", 2000);
        check_eq("t2_npulse", 32'(order.size()), 4);
        n = 0;
        foreach (order[i]) n += order[i];
        check_eq("t2_all_phi", 32'(n), 4);
        check_eq("t2_len_stable", 32'(len_bad), 0);
        check_eq("t2_len", 32'(thr_step_len), 2);
        tick();
        check_eq("t2_busy_after", 32'(busy), 0);
        check_eq("t2_busy_bad", 32'(busy_bad), 0);

        // Zero-step command
        clear_log();
        send_cmd(0, 0, 7);
        wait_done("t3_timeout", 20);
        check_eq("t3_latency", 32'(done_cyc - acc_cyc), 2);
        check_eq("t3_thr_n", 32'(thr_n), 0);
        check_eq("t3_npulse", 32'(order.size()), 0);
        tick();

        // step_len = 0: one theta, one phi, 5 clocks apart
        clear_log();
        send_cmd(1, 1, 0);
        wait_done("t4_timeout", 100);
        check_eq("t4_npulse", 32'(order.size()), 2);
        if (order.size() == 2) begin
            check_eq("t4_first", 32'(order[0]), 0);
            check_eq("t4_second", 32'(order[1]), 1);
            check_eq("t4_gap", 32'(times[1] - times[0]), 5);
            check_eq("t4_done_after", 32'(done_cyc - times[1]), 1);
        end
        tick();

        // Abort in the fifth STEP cycle
        clear_log();
        send_cmd(10, 10, 3);
        n = 0;
        while (order.size() < 4 && n < 2000) begin tick(); n++; end
        check_eq("t5_four", 32'(order.size()), 4);
        n = 0;
        while (!thr_start && n < 20) begin tick(); n++; end
        tick();            // ARM
        tick();            // WAIT
        n = 0;
        while (!thr_done && n < 200) begin tick(); n++; end
        tick();            // STEP
        check_eq("t5_left_pre", 32'({theta_left, phi_left}), {16'd8, 16'd8});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("t5_done", 32'(move_done), 1);
        check_eq("t5_aborted", 32'(aborted), 1);
        check_eq("t5_left", 32'({theta_left, phi_left}), 0);
        check_eq("t5_no_pulse", 32'(order.size()), 4);
        check_eq("t5_busy", 32'(busy), 0);
        tick(); tick();
        check_eq("t5_abort_held", 32'(aborted), 1);
        clear_log();
        send_cmd(1, 0, 0);
        check_eq("t5_abort_clr", 32'(aborted), 0);
        wait_done("t5b_timeout", 100);
        check_eq("t5b_npulse", 32'(order.size()), 1);
        tick();

        // cmd_valid while busy, then async reset in WAIT
        clear_log();
        send_cmd(2, 2, 4);
        cmd_theta_steps = CNT_W'(7);
        cmd_valid = 1'b1;
        n = 0;
        while (order.size() < 1 && n < 2000) begin tick(); n++; end
        check_eq("t6_theta_left", 32'(theta_left), 1);
        check_eq("t6_ready", 32'(cmd_ready), 0);
        n = 0;
        while (!thr_start && n < 20) begin tick(); n++; end
        tick();            // ARM
        tick();            // WAIT
        #10 rst = 1'b1;
        #1;
        check_eq("t6_rst_ready", 32'(cmd_ready), 1);
        check_eq("t6_rst_busy", 32'(busy), 0);
        check_eq("t6_rst_state", 32'({theta_left, phi_left, thr_step_len}), 0);
        check_eq("t6_rst_done", 32'(move_done), 0);
        cmd_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        check_eq("t6_no_done", 32'(done_n), 0);
        check_eq("t6_idle", 32'({cmd_ready, busy}), 32'(2'b10));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
